model2axis_packer: RTL and testbench
====================================

# model2axis_packer

Result-return stage that sits directly downstream of the command interpreter driving the DUT memory model. It consumes the 32-bit read results that interpreter emits on `dut_data`/`dut_valid` and buffers them in an internal FIFO. It frames them into header-prefixed AXI-Stream packets with `tlast`, and drives them toward the GTP transmit path (`core2gtp_*`), honouring back-pressure.

## Interface

Parameters:
- `FIFO_DEPTH`, 64: result FIFO entries; must be a power of two, ≥ 2·`PKT_LEN`.
- `PKT_LEN`, 16: maximum payload words per packet, 1..255.
- `TIMEOUT`, 256: idle cycles before a partial packet is flushed, ≥ 2.
- `HDR_TAG`, 8'h81: value of header bits [31:24].

Ports:
- `core_clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dut_data`  in  32  read result word.
- `dut_valid`  in  1  one-cycle qualifier for `dut_data`; no ready is returned.
- `core2gtp_tdata`  out  32  header or payload word.
- `core2gtp_tvalid`  out  1  output word valid.
- `core2gtp_tready`  in  1  downstream accept.
- `core2gtp_tlast`  out  1  high on the last payload word of a packet.
- `overflow`  out  1  sticky: a result was dropped because the FIFO was full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- **Reset values:** all outputs 0, FIFO empty, FSM in IDLE, timeout counter 0.
- **Write side:**
  - A word is pushed on each edge where `dut_valid`=1 and the FIFO is not full.
  - When the FIFO is full at that edge, the word is dropped and `overflow` is set. This holds even if a pop happens in the same cycle.
  - `overflow` clears only on `rst`.
- **FSM states:** IDLE → HDR → PAYLOAD → IDLE.
- **IDLE:**
  - Launch when `fifo_level` ≥ `PKT_LEN`, or when the timeout has fired and `fifo_level` ≥ 1.
  - On launch, latch `len` = min(`fifo_level`, `PKT_LEN`) (8 bits) and go to HDR.
- **HDR:**
  - Drive `tdata` = {`HDR_TAG`, 8'h00, 8'h00, `len`}, `tvalid`=1, `tlast`=0.
  - On `tready`, go to PAYLOAD.
- **PAYLOAD:**
  - Drive FIFO head words; decrement the remaining count on each `tvalid&tready`.
  - `tlast`=1 when remaining count = 1.
  - The handshake on the last word returns the FSM to IDLE.
- **Timeout counter:**
  - Counts only in IDLE with `fifo_level` ≥ 1 and `dut_valid`=0.
  - Cleared by `dut_valid`, by launch, and whenever the FIFO is empty.
  - Saturates at `TIMEOUT`; "fired" means counter == `TIMEOUT`.
- **Handshake rules:**
  - Once `tvalid` rises, `tdata`, `tlast` and `tvalid` are held stable until `tready`.
  - Payload words are never reordered or repeated.
- Writes continue during HDR/PAYLOAD. Words arriving mid-packet go into a later packet; the latched `len` is never changed.
- **Mid-packet reset:** outputs drop to 0 asynchronously, FIFO contents are discarded, no partial packet is resumed.

## Timing

- **Write to occupancy:** `dut_valid` at edge N → `fifo_level` increments after edge N.
- **Launch latency:** `fifo_level` reaching `PKT_LEN` after edge N → IDLE launches at edge N+1 → header `tvalid` visible after edge N+1. One idle cycle is allowed between packets.
- **Throughput:** with `tready` held high, payload runs one word per cycle, back-to-back after the header.
- **Timeout latency:** last `dut_valid` at edge N with a partial FIFO → header `tvalid` after edge N+`TIMEOUT`+1.
- **Simultaneous push and pop:** `fifo_level` is unchanged.

## Configuration

- Macro: `MODEL2AXIS_TIMEOUT_EN`.
- **Defined:** the timeout flush works as described.
- **Undefined:**
  - The timeout counter is not built; packets launch only at `fifo_level` ≥ `PKT_LEN`.
  - Partial data remains buffered until more results arrive.
  - The `TIMEOUT` parameter is ignored.

## Structure

- Shared package `model_if_pkg` holds:
  - the FSM state enum (IDLE, HDR, PAYLOAD);
  - header field positions (tag [31:24], length [7:0]);
  - the default `HDR_TAG` constant.
- One sub-module, `model2axis_fifo`: synchronous first-word-fall-through FIFO with `full`, `empty` and `level` outputs. The packer contains only the FSM, the length counter, the timeout counter and overflow tracking.

## Test plan

- **Full packet:** `PKT_LEN`=4, 4 pulses `dut_valid` with data 0xA0..0xA3, `tready`=1 → header 0x81000004, then A0, A1, A2, A3, with `tlast` only on A3, in 5 consecutive cycles.
- **Timeout flush:** `TIMEOUT`=8, 2 words 0x11/0x22 then silence → header 0x81000002 appears 9 cycles after the last write, followed by 0x11, then 0x22 with `tlast`. With the macro undefined, no output for 1000 cycles.
- **Back-pressure:** `tready` toggles 1010… during a packet → every word is held stable while `tready`=0, the sequence is identical to the unstalled case, and none are lost.
- **Overflow:** `FIFO_DEPTH`=8, `PKT_LEN`=4, `tready`=0, 10 writes → `fifo_level`=8, `overflow`=1, words 9–10 absent from later output.
- **Overlapping arrivals:** 6 writes with `PKT_LEN`=4 → first packet has `len` 4; the remaining 2 words form a second packet with `len` 2 after the timeout.
- **Reset mid-payload:** assert `rst` after the header plus 1 payload word → `tvalid`=0 immediately, `fifo_level`=0, and after release the next 4 writes produce a clean header 0x81000004.

Source files
------------

// File: rtl/model_if_pkg.sv
// model_if_pkg: shared types and header layout for the model-to-AXI-Stream
// result return path.
package model_if_pkg;

  // Packer FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } pkt_state_e;

  // Header field positions
  localparam int unsigned HDR_TAG_MSB = 31;
  localparam int unsigned HDR_TAG_LSB = 24;
  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 0;

  localparam logic [7:0] HDR_TAG_DEFAULT = 8'h81;

  // Header word: tag in the top byte, payload length in the bottom byte
  function automatic logic [31:0] make_header(input logic [7:0] tag,
                                              input logic [7:0] len);
    logic [31:0] w;
    w = '0;
    w[HDR_TAG_MSB:HDR_TAG_LSB] = tag;
    w[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return w;
  endfunction

endpackage

// File: rtl/model2axis_fifo.sv
// model2axis_fifo: synchronous first-word-fall-through FIFO. Exposes the head
// word and the word behind it so the packer can register its output data.
module model2axis_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign head    = mem_q[rd_ptr_q];
  assign next    = mem_q[rd_nxt];

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_nxt;
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/model2axis_packer.sv
// model2axis_packer: buffers memory-model read results and frames them into
// header-prefixed AXI-Stream packets. Define MODEL2AXIS_TIMEOUT_EN to build the
// idle-timeout flush of partial packets.
module model2axis_packer
  import model_if_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned PKT_LEN    = 16,
  parameter int unsigned TIMEOUT    = 256,
  parameter logic [7:0]  HDR_TAG    = HDR_TAG_DEFAULT,
  localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          core_clk,
  input  logic          rst,
  input  logic [31:0]   dut_data,
  input  logic          dut_valid,
  output logic [31:0]   core2gtp_tdata,
  output logic          core2gtp_tvalid,
  input  logic          core2gtp_tready,
  output logic          core2gtp_tlast,
  output logic          overflow,
  output logic [LW-1:0] fifo_level
);

  localparam logic [LW-1:0] PKT_LEN_L = LW'(PKT_LEN);
  localparam int unsigned   TW        = $clog2(TIMEOUT + 1);

  if (PKT_LEN < 1 || PKT_LEN > 255) begin : g_bad_pkt_len
    $error("model2axis_packer: PKT_LEN out of range");
  end
  if (FIFO_DEPTH < 2 * PKT_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("model2axis_packer: FIFO_DEPTH must be a power of two >= 2*PKT_LEN");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("model2axis_packer: TIMEOUT must be >= 2");
  end

  pkt_state_e  state_q, state_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [7:0]  rem_q, rem_d;
  logic        overflow_q, overflow_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_head, fifo_next;
  logic [LW-1:0] level;
  logic        launch, timeout_fired;
  logic [7:0]  launch_len;

  model2axis_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (core_clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (dut_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .next      (fifo_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign fifo_push       = dut_valid & ~fifo_full;
  assign fifo_level      = level;
  assign core2gtp_tdata  = tdata_q;
  assign core2gtp_tvalid = tvalid_q;
  assign core2gtp_tlast  = tlast_q;
  assign overflow        = overflow_q;

`ifdef MODEL2AXIS_TIMEOUT_EN
  logic [TW-1:0] tmo_q, tmo_d;

  // Idle timeout counter, saturating at TIMEOUT
  always_comb begin
    tmo_d = tmo_q;
    if (dut_valid || launch || fifo_empty) tmo_d = '0;
    else if (state_q == ST_IDLE && tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + TW'(1);
    timeout_fired = (tmo_q == TW'(TIMEOUT));
  end
`else
  // Partial packets wait for more data when the timeout is not built
  always_comb timeout_fired = 1'b0;
`endif

  // Packet framing FSM next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    rem_d      = rem_q;
    overflow_d = overflow_q | (dut_valid & fifo_full);
    fifo_pop   = 1'b0;
    launch     = 1'b0;
    launch_len = (level >= PKT_LEN_L) ? 8'(PKT_LEN) : 8'(level);
    case (state_q)
      ST_IDLE: begin
        if (level >= PKT_LEN_L || (timeout_fired && !fifo_empty)) begin
          launch   = 1'b1;
          state_d  = ST_HDR;
          rem_d    = launch_len;
          tdata_d  = make_header(HDR_TAG, launch_len);
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      ST_HDR: begin
        if (core2gtp_tready) begin
          state_d = ST_PAYLOAD;
          tdata_d = fifo_head;
          tlast_d = (rem_q == 8'd1);
        end
      end
      ST_PAYLOAD: begin
        if (core2gtp_tready) begin
          fifo_pop = 1'b1;
          rem_d    = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d  = ST_IDLE;
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            // Output data is registered, so load the word behind the head
            // being popped this cycle.
            tdata_d = fifo_next;
            tlast_d = (rem_q == 8'd2);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tdata_d  = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // State, output and counter registers
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      rem_q      <= '0;
      overflow_q <= 1'b0;
`ifdef MODEL2AXIS_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      rem_q      <= rem_d;
      overflow_q <= overflow_d;
`ifdef MODEL2AXIS_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_model2axis_packer.sv
// tb_model2axis_packer: directed self-checking bench for model2axis_packer
// (FIFO_DEPTH=8, PKT_LEN=4, TIMEOUT=8).
module tb_model2axis_packer;

  logic        core_clk = 1'b0;
  logic        rst;
  logic [31:0] dut_data;
  logic        dut_valid;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        overflow;
  logic [3:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  logic [31:0] cap_d [0:15];
  logic        cap_l [0:15];
  int          cap_n;

  model2axis_packer #(
    .FIFO_DEPTH (8),
    .PKT_LEN    (4),
    .TIMEOUT    (8),
    .HDR_TAG    (8'h81)
  ) dut (
    .core_clk        (core_clk),
    .rst             (rst),
    .dut_data        (dut_data),
    .dut_valid       (dut_valid),
    .core2gtp_tdata  (tdata),
    .core2gtp_tvalid (tvalid),
    .core2gtp_tready (tready),
    .core2gtp_tlast  (tlast),
    .overflow        (overflow),
    .fifo_level      (fifo_level)
  );

  always #5 core_clk = ~core_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge core_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      dut_data  = base + 32'(i);
      dut_valid = 1'b1;
      tick();
    end
    dut_valid = 1'b0;
    dut_data  = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Accept n words; toggle drives tready 1,0,1,0... and checks stall stability
  task automatic collect(input int n, input bit toggle, input int budget);
    logic        prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    cap_n      = 0;
    for (int c = 0; c < budget && cap_n < n; c++) begin
      if (prev_stall) begin
        chk("hold_tvalid", 32'(tvalid), 32'd1);
        chk("hold_tdata", tdata, prev_d);
        chk("hold_tlast", 32'(tlast), 32'(prev_l));
      end
      tready     = toggle ? (c % 2 == 0) : 1'b1;
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_l     = tlast;
      if (tvalid && tready) begin
        cap_d[cap_n] = tdata;
        cap_l[cap_n] = tlast;
        cap_n++;
      end
      tick();
    end
    tready = 1'b0;
    chk("collect_count", 32'(cap_n), 32'(n));
  endtask

  task automatic check_pkt(input string tag, input int off, input logic [31:0] hdr,
                           input logic [31:0] base, input int n);
    chk({tag, "_hdr"}, cap_d[off], hdr);
    chk({tag, "_hdr_last"}, 32'(cap_l[off]), 32'd0);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, cap_d[off+1+i], base + 32'(i));
      chk({tag, "_last"}, 32'(cap_l[off+1+i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    logic [31:0] exp_d [0:4];
    int          seen;

    rst       = 1'b1;
    dut_valid = 1'b0;
    dut_data  = '0;
    tready    = 1'b0;
    repeat (2) tick();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    tick();

    // Full packet, tready high: header then four words on consecutive cycles
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dut_data  = 32'hA0 + 32'(i);
      dut_valid = 1'b1;
      tick();
      chk("t1_level", 32'(fifo_level), 32'(i + 1));
      chk("t1_idle", 32'(tvalid), 32'd0);
    end
    dut_valid = 1'b0;
    exp_d[0] = 32'h81000004;
    exp_d[1] = 32'hA0;
    exp_d[2] = 32'hA1;
    exp_d[3] = 32'hA2;
    exp_d[4] = 32'hA3;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_tvalid", 32'(tvalid), 32'd1);
      chk("t1_tdata", tdata, exp_d[k]);
      chk("t1_tlast", 32'(tlast), 32'(k == 4));
    end
    tick();
    chk("t1_done_tvalid", 32'(tvalid), 32'd0);
    chk("t1_done_level", 32'(fifo_level), 32'd0);

    // Timeout flush of a two-word partial packet
    dut_data = 32'h11; dut_valid = 1'b1; tick();
    dut_data = 32'h22; tick();
    dut_valid = 1'b0; dut_data = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t2_wait_tvalid", 32'(tvalid), 32'd0);
    end
    tick();
`ifdef MODEL2AXIS_TIMEOUT_EN
    chk("t2_hdr_tvalid", 32'(tvalid), 32'd1);
    chk("t2_hdr", tdata, 32'h81000002);
    tick();
    chk("t2_w0", tdata, 32'h11);
    chk("t2_w0_last", 32'(tlast), 32'd0);
    tick();
    chk("t2_w1", tdata, 32'h22);
    chk("t2_w1_last", 32'(tlast), 32'd1);
    tick();
    chk("t2_done_tvalid", 32'(tvalid), 32'd0);
`else
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      if (tvalid) seen++;
      tick();
    end
    chk("t2_no_output", 32'(seen), 32'd0);
    chk("t2_level_held", 32'(fifo_level), 32'd2);
    do_reset();
`endif

    // Back-pressure with tready toggling 1,0,1,0...
    tready = 1'b0;
    write_words(32'hB0, 4);
    collect(5, 1'b1, 100);
    check_pkt("t3", 0, 32'h81000004, 32'hB0, 4);
    tick();
    chk("t3_done_tvalid", 32'(tvalid), 32'd0);
    chk("t3_done_level", 32'(fifo_level), 32'd0);

    // Overflow: ten writes into an eight-entry FIFO with no drain
    tready = 1'b0;
    write_words(32'hC0, 10);
    chk("t4_level_full", 32'(fifo_level), 32'd8);
    chk("t4_overflow", 32'(overflow), 32'd1);
    collect(10, 1'b0, 100);
    check_pkt("t4_p1", 0, 32'h81000004, 32'hC0, 4);
    check_pkt("t4_p2", 5, 32'h81000004, 32'hC4, 4);
    repeat (3) tick();
    chk("t4_drained_level", 32'(fifo_level), 32'd0);
    chk("t4_drained_tvalid", 32'(tvalid), 32'd0);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);

    // Overlapping arrivals: six words form a full packet and a partial one
    tready = 1'b0;
    write_words(32'hD0, 6);
`ifdef MODEL2AXIS_TIMEOUT_EN
    collect(8, 1'b0, 100);
    check_pkt("t5_p1", 0, 32'h81000004, 32'hD0, 4);
    check_pkt("t5_p2", 5, 32'h81000002, 32'hD4, 2);
    tick();
    chk("t5_done_level", 32'(fifo_level), 32'd0);
`else
    collect(5, 1'b0, 100);
    check_pkt("t5_p1", 0, 32'h81000004, 32'hD0, 4);
    seen = 0;
    tready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (tvalid) seen++;
      tick();
    end
    tready = 1'b0;
    chk("t5_no_second", 32'(seen), 32'd0);
    chk("t5_level_held", 32'(fifo_level), 32'd2);
    do_reset();
`endif

    // Reset after the header and one payload word
    tready = 1'b0;
    write_words(32'hE0, 4);
    tick();
    chk("t6_hdr_tvalid", 32'(tvalid), 32'd1);
    chk("t6_hdr", tdata, 32'h81000004);
    tready = 1'b1;
    tick();
    chk("t6_w0", tdata, 32'hE0);
    tick();
    chk("t6_w1", tdata, 32'hE1);
    tready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 32'(tvalid), 32'd0);
    chk("t6_rst_tdata", tdata, 32'd0);
    chk("t6_rst_tlast", 32'(tlast), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_tvalid", 32'(tvalid), 32'd0);
    write_words(32'hF0, 4);
    collect(5, 1'b0, 50);
    check_pkt("t6_clean", 0, 32'h81000004, 32'hF0, 4);
    tick();
    chk("t6_done_level", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
